mod_exp_ctrl: RTL
=================

Name: mod_exp_ctrl

Overview:
- Modular-exponentiation sequencer; computes result = base^exp mod m by left-to-right square-and-multiply.
- Initiator side of the modular-multiplier interface (enable_p pulse / a, b, m operands / y result / done_irq_p pulse).
- Does not instantiate the multiplier; the top level connects mm_* ports to any mod_mul_il-style multiplier with the same NBITS.

Parameters:
- NBITS, 4096, operand/modulus/result width
- EBITS, 4096, exponent width
- WDOG_CYC, 0, max cycles to wait for mm_done_irq_p per operation; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_p  in  1  one-cycle start pulse; honoured only in IDLE
- base  in  NBITS  base; sampled on start_p
- exp  in  EBITS  exponent; sampled on start_p
- m  in  NBITS  modulus; sampled on start_p
- result  out  NBITS  final value; valid from done_p, held until the next accepted start_p
- done_p  out  1  one-cycle completion pulse
- err  out  1  error flag; valid with done_p, held until the next accepted start_p
- busy  out  1  high in every state except IDLE
- mm_enable_p  out  1  one-cycle multiply request
- mm_a  out  NBITS  multiplier operand X
- mm_b  out  NBITS  multiplier operand Y
- mm_m  out  NBITS  multiplier modulus
- mm_y  in  NBITS  multiplier product
- mm_done_irq_p  in  1  one-cycle multiplier completion pulse

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Reset mid-operation: immediate return to IDLE, no done_p. A multiplier completion arriving after reset is ignored.
- States: IDLE, CHECK, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
- IDLE
  - On start_p: latch base, exp and m; clear err; go to CHECK.
  - start_p in any other state is ignored.
- CHECK (1 cycle)
  - m < 2 or base >= m: err=1, result=0, go to DONE.
  - exp == 0: result=1, go to DONE.
  - Otherwise go to SCAN.
  - Both the error and exp==0 paths issue no multiplier operations.
- SCAN
  - Shift the exponent register left 1 bit per cycle until the MSB is 1.
  - On finding it: R=base, shift once more, remaining = L-1, where L is the exponent bit length.
  - remaining == 0: go to DONE. Otherwise go to SQR_REQ.
- SQR_REQ (1 cycle)
  - Drive mm_a=R, mm_b=R, mm_m=m, mm_enable_p=1; go to SQR_WAIT.
- SQR_WAIT
  - On mm_done_irq_p: R=mm_y.
  - If the current exponent MSB is 1, go to MUL_REQ; otherwise go to NEXT handling.
- MUL_REQ / MUL_WAIT
  - Same as the square states, with mm_a=R and mm_b=base.
- NEXT handling (done inside the WAIT transition)
  - Shift the exponent and decrement remaining.
  - remaining reaches 0: go to DONE. Otherwise go to SQR_REQ.
- Operand hold: mm_a, mm_b and mm_m stay stable from the mm_enable_p cycle through the mm_done_irq_p cycle.
- Request gap: there is at least 1 cycle between mm_done_irq_p and the next mm_enable_p.
- mm_done_irq_p outside the WAIT states is ignored.
- Watchdog (WDOG_CYC > 0): counter cleared on entry to a WAIT state. If it reaches WDOG_CYC without mm_done_irq_p: err=1, result=0, go to DONE.
- DONE: done_p=1 for one cycle; result valid; go to IDLE.
- Multiplier operation count: (L-1) squarings plus (H-1) multiplies, where H is the Hamming weight of exp.
- Latency with no multiplier operations: done_p two cycles after the start_p cycle (exp==0 or error).

Test Plan:
- base=3, exp=5, m=7, multiplier model latency 10 -> three mm_enable_p pulses with (a,b) = (3,3), (2,2), (4,3); result=5, err=0, single done_p.
- base=2, exp=0, m=11 -> no mm_enable_p; done_p 2 cycles after start_p; result=1.
- base=5, exp=1, m=13 -> no mm_enable_p; result=5.
- m=1, or base=9 with m=7 -> err=1, result=0, no mm_enable_p.
- WDOG_CYC=20 with a multiplier model that never completes -> done_p 20 cycles after entering SQR_WAIT; err=1.
- Second start_p while busy, plus a spurious mm_done_irq_p while in SCAN -> both ignored; result matches the first operation.
- rst_n low during MUL_WAIT -> all outputs 0 immediately; no done_p; the next start_p runs correctly.

Source files
------------

// File: rtl/mod_exp_ctrl.sv
// Modular-exponentiation sequencer: result = base^exp mod m by left-to-right
// square-and-multiply, driving an external enable/done style modular multiplier.
module mod_exp_ctrl #(
  parameter int NBITS    = 4096,
  parameter int EBITS    = 4096,
  parameter int WDOG_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             done_p,
  output logic             err,
  output logic             busy,
  output logic             mm_enable_p,
  output logic [NBITS-1:0] mm_a,
  output logic [NBITS-1:0] mm_b,
  output logic [NBITS-1:0] mm_m,
  input  logic [NBITS-1:0] mm_y,
  input  logic             mm_done_irq_p
);

  localparam int CW = $clog2(EBITS + 1);
  localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LAST = (WDOG_CYC > 0) ? WW'(WDOG_CYC - 1) : '0;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] SCAN     = 3'd2;
  localparam logic [2:0] SQR_REQ  = 3'd3;
  localparam logic [2:0] SQR_WAIT = 3'd4;
  localparam logic [2:0] MUL_REQ  = 3'd5;
  localparam logic [2:0] MUL_WAIT = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  logic [2:0]       state;
  logic [NBITS-1:0] base_r;
  logic [NBITS-1:0] m_r;
  logic [NBITS-1:0] r_r;
  logic [EBITS-1:0] exp_r;
  logic [CW-1:0]    remaining;
  logic [WW-1:0]    wdog_cnt;

  logic exp_msb;
  logic sqr_st;
  logic mul_st;
  logic wait_st;
  logic wdog_hit;

  assign exp_msb  = exp_r[EBITS-1];
  assign sqr_st   = (state == SQR_REQ) || (state == SQR_WAIT);
  assign mul_st   = (state == MUL_REQ) || (state == MUL_WAIT);
  assign wait_st  = (state == SQR_WAIT) || (state == MUL_WAIT);
  assign wdog_hit = (WDOG_CYC > 0) && wait_st && !mm_done_irq_p && (wdog_cnt == WDOG_LAST);

  // Operands are decoded from state so they cannot move while a multiply is
  // outstanding; R only changes on the edge that closes the done cycle.
  assign mm_a   = (sqr_st || mul_st) ? r_r : '0;
  assign mm_b   = sqr_st ? r_r : (mul_st ? base_r : '0);
  assign mm_m   = (sqr_st || mul_st) ? m_r : '0;
  assign busy   = (state != IDLE);
  assign done_p = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_r      <= '0;
      m_r         <= '0;
      r_r         <= '0;
      exp_r       <= '0;
      remaining   <= '0;
      wdog_cnt    <= '0;
      result      <= '0;
      err         <= 1'b0;
      mm_enable_p <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch
      // reads the pre-edge values of r_r, exp_r and remaining.
      mm_enable_p <= 1'b0;
      case (state)
        IDLE: begin
          if (start_p) begin
            base_r <= base;
            exp_r  <= exp;
            m_r    <= m;
            err    <= 1'b0;
            state  <= CHECK;
          end
        end

        CHECK: begin
          if ((m_r < NBITS'(2)) || (base_r >= m_r)) begin
            err    <= 1'b1;
            result <= '0;
            state  <= DONE;
          end else if (exp_r == '0) begin
            result <= NBITS'(1);
            state  <= DONE;
          end else begin
            remaining <= CW'(EBITS);
            state     <= SCAN;
          end
        end

        // Every shift consumes one exponent bit, so once the leading one has
        // been shifted out, remaining equals L-1.
        SCAN: begin
          exp_r     <= exp_r << 1;
          remaining <= remaining - 1'b1;
          if (exp_msb) begin
            r_r <= base_r;
            if (remaining == CW'(1)) begin
              result <= base_r;
              state  <= DONE;
            end else begin
              state <= SQR_REQ;
            end
          end
        end

        // The request is registered, so the pulse lands in the first WAIT
        // cycle and is always at least one cycle after the previous done.
        SQR_REQ, MUL_REQ: begin
          mm_enable_p <= 1'b1;
          wdog_cnt    <= '0;
          state       <= (state == SQR_REQ) ? SQR_WAIT : MUL_WAIT;
        end

        SQR_WAIT, MUL_WAIT: begin
          if (mm_done_irq_p) begin
            r_r <= mm_y;
            if ((state == SQR_WAIT) && exp_msb) begin
              state <= MUL_REQ;
            end else begin
              exp_r     <= exp_r << 1;
              remaining <= remaining - 1'b1;
              if (remaining == CW'(1)) begin
                result <= mm_y;
                state  <= DONE;
              end else begin
                state <= SQR_REQ;
              end
            end
          end else if (wdog_hit) begin
            err    <= 1'b1;
            result <= '0;
            state  <= DONE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
